multi_debounce: RTL and testbench



---
 rtl/multi_debounce.sv | 121 ++++++++++++
 tb/tb_multi_debounce.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// multi_debounce: multi-channel debouncer with one-cycle rise/fall pulses.
// A shared prescaler produces a sample tick every TICK_DIV clk_in cycles.
// Each channel accepts a new level once STABLE_SAMPLES consecutive ticks
// have sampled a value that differs from the current debounced level.
//
// Optional feature: define MULTI_DEBOUNCE_SYNC2_EN to place a 2-flop
// synchroniser (reset to RESET_LEVEL) in front of each channel. Without it,
// signal_in is sampled directly and must already be synchronous to clk_in.
//
// Ports:
//   clk_in       system clock, all state on rising edge
//   reset        synchronous active-high reset
//   signal_in    raw inputs, one bit per channel
//   level_out    debounced level per channel (registered)
//   rise_pulse   one-cycle pulse on accepted 0->1 (registered)
//   fall_pulse   one-cycle pulse on accepted 1->0 (registered)
//   event_valid  OR of all rise/fall pulse bits (no added latency)
module multi_debounce #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter logic        RESET_LEVEL    = 1'b0
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                event_valid
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(STABLE_SAMPLES + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [CHANNELS-1:0] LEVEL_RST = {CHANNELS{RESET_LEVEL}};

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] samp_c;
  logic                tick_c;

`ifdef MULTI_DEBOUNCE_SYNC2_EN
  logic [CHANNELS-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser; the second stage is the sample source.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q <= LEVEL_RST;
      sync2_q <= LEVEL_RST;
    end else begin
      sync1_q <= signal_in;
      sync2_q <= sync1_q;
    end
  end

  assign samp_c = sync2_q;
`else
  assign samp_c = signal_in;
`endif

  // With TICK_DIV == 1 the prescaler sits at 0 and the tick is constant.
  assign tick_c = (presc_q == PRESC_MAX);

  // Next-state: prescaler wrap and per-channel stability counting.
  always_comb begin
    presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_c) begin
        if (samp_c[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          // This tick is the STABLE_SAMPLES-th differing sample: accept it.
          level_d[i] = samp_c[i];
          cnt_d[i]   = '0;
          rise_d[i]  = samp_c[i];
          fall_d[i]  = ~samp_c[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset overrides any tick and discards pending counts.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      presc_q <= '0;
      level_q <= LEVEL_RST;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_out   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_valid = |(rise_q | fall_q);

endmodule

// File: tb/tb_multi_debounce.sv
// Testbench for multi_debounce: two instances with different tick/stability
// settings. Expected acceptance events are queued when inputs are driven and
// compared every cycle against pulses, levels and event_valid.
module tb_multi_debounce;

`ifdef MULTI_DEBOUNCE_SYNC2_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  localparam int TD_A = 1;
  localparam int SS_A = 3;
  localparam int TD_B = 4;
  localparam int SS_B = 4;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] sig_a, sig_b;
  logic [3:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
  logic       ev_a, ev_b;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ra, rb;
  bit   mon_en = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [3:0] lvl_a_exp, lvl_b_exp;

  multi_debounce #(
    .CHANNELS(4), .TICK_DIV(TD_A), .STABLE_SAMPLES(SS_A), .RESET_LEVEL(1'b0)
  ) dut_a (
    .clk_in(clk), .reset(rst_a), .signal_in(sig_a), .level_out(lvl_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .event_valid(ev_a)
  );

  multi_debounce #(
    .CHANNELS(4), .TICK_DIV(TD_B), .STABLE_SAMPLES(SS_B), .RESET_LEVEL(1'b1)
  ) dut_b (
    .clk_in(clk), .reset(rst_b), .signal_in(sig_b), .level_out(lvl_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .event_valid(ev_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Edge at which a value first sampled at edge c is accepted, given the
  // last reset edge r: ticks fall on edges r+td, r+2td, ...
  function automatic int acc_cyc(input int c, input int r, input int td, input int ss);
    int t = c;
    while ((t - r) % td != 0) t++;
    return t + (ss - 1) * td;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    logic [3:0] er, ef;
    if (mon_en) begin
      er = '0;
      ef = '0;
      if (q_a.size() > 0 && q_a[0].cyc == cyc) begin
        e = q_a.pop_front();
        er = e.rise;
        ef = e.fall;
        lvl_a_exp = e.level;
      end
      chk("a_level", lvl_a, lvl_a_exp);
      chk("a_rise", rise_a, er);
      chk("a_fall", fall_a, ef);
      chk("a_event", {3'b0, ev_a}, {3'b0, |(er | ef)});
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    logic [3:0] er, ef;
    if (mon_en) begin
      er = '0;
      ef = '0;
      if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
        e = q_b.pop_front();
        er = e.rise;
        ef = e.fall;
        lvl_b_exp = e.level;
      end
      chk("b_level", lvl_b, lvl_b_exp);
      chk("b_rise", rise_b, er);
      chk("b_fall", fall_b, ef);
      chk("b_event", {3'b0, ev_b}, {3'b0, |(er | ef)});
    end
  end

  initial begin
    int t0;
    int budget;
    rst_a = 1'b1;
    rst_b = 1'b1;
    sig_a = 4'h0;
    sig_b = 4'hF;
    wait_cyc(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    ra = cyc;
    rb = cyc;
    lvl_a_exp = 4'h0;
    lvl_b_exp = 4'hF;
    mon_en = 1'b1;

    // Inputs held at reset level: no events for 50 cycles.
    wait_cyc(50);

    // Clean rise on channel 0 of instance A.
    sig_a[0] = 1'b1;
    q_a.push_back('{acc_cyc(cyc + 1 + SL, ra, TD_A, SS_A), 4'b0001, 4'b0000, 4'b0001});
    wait_cyc(8);

    // Channel 1 rises, then ch1 falls and ch2 rises together.
    sig_a = 4'b0011;
    q_a.push_back('{acc_cyc(cyc + 1 + SL, ra, TD_A, SS_A), 4'b0010, 4'b0000, 4'b0011});
    wait_cyc(8);
    sig_a = 4'b0101;
    q_a.push_back('{acc_cyc(cyc + 1 + SL, ra, TD_A, SS_A), 4'b0100, 4'b0010, 4'b0101});
    wait_cyc(8);

    // Short glitches on channel 3 never reach SS_A samples.
    sig_a[3] = 1'b1;
    wait_cyc(1);
    sig_a[3] = 1'b0;
    wait_cyc(2);
    sig_a[3] = 1'b1;
    wait_cyc(2);
    sig_a[3] = 1'b0;
    wait_cyc(6);

    // Instance B: 12-cycle excursion spans only 3 ticks, so it is rejected.
    sig_b[0] = 1'b0;
    wait_cyc(12);
    sig_b[0] = 1'b1;
    wait_cyc(8);

    // Sustained change is accepted once; then return high at another phase.
    sig_b[0] = 1'b0;
    q_b.push_back('{acc_cyc(cyc + 1 + SL, rb, TD_B, SS_B), 4'b0000, 4'b0001, 4'b1110});
    wait_cyc(20);
    wait_cyc(1);
    sig_b[0] = 1'b1;
    q_b.push_back('{acc_cyc(cyc + 1 + SL, rb, TD_B, SS_B), 4'b0001, 4'b0000, 4'b1111});
    wait_cyc(20);

    // Reset after 3 differing ticks on channel 1 discards the count.
    sig_b[1] = 1'b0;
    t0 = acc_cyc(cyc + 1 + SL, rb, TD_B, 1);
    do @(negedge clk); while (cyc < t0 + 2 * TD_B);
    rst_b = 1'b1;
    wait_cyc(2);
    rst_b = 1'b0;
    rb = cyc;
    q_b.push_back('{acc_cyc(cyc + 1 + SL, rb, TD_B, SS_B), 4'b0000, 4'b0010, 4'b1101});
    wait_cyc(25);

    // Drain: every queued event must have been observed.
    budget = 200;
    while ((q_a.size() > 0 || q_b.size() > 0) && budget > 0) begin
      wait_cyc(1);
      budget--;
    end
    chk("a_queue_empty", 4'(q_a.size()), 4'h0);
    chk("b_queue_empty", 4'(q_b.size()), 4'h0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
